// File: rtl/wmaster_pkg.sv
// Shared definitions for the wmaster bus initiator: bus widths, the SSP
// address decode constant, FSM state encoding and the packed command word.
package wmaster_pkg;

  localparam int unsigned ADR_W = 26;
  localparam int unsigned DAT_W = 32;

  // Address bit that selects the SSP range on the slave bridge.
  localparam logic [ADR_W-1:0] SSP_DATA_ADR = 26'h0010000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
  } cmd_t;

  function automatic logic is_ssp(input logic [ADR_W-1:0] adr);
    return |(adr & SSP_DATA_ADR);
  endfunction

endpackage

// File: rtl/wmaster_cmd_fifo.sv
// Command FIFO for wmaster.
// Synchronous FIFO of FIFO_DEPTH command words with registered read/write
// pointers and an occupancy count. Pointers wrap modulo FIFO_DEPTH.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset (flushes the FIFO)
//   push_i        write push_data_i (ignored when full)
//   push_data_i   command word to store
//   pop_i         advance the head (ignored when empty)
//   full_o        FIFO holds FIFO_DEPTH entries
//   empty_o       FIFO holds no entries
//   head_o        oldest stored command
module wmaster_cmd_fifo
  import wmaster_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  cmd_t push_data_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output cmd_t head_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("wmaster_cmd_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  cmd_t             mem_q [FIFO_DEPTH];
  cmd_t             mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/wmaster.sv
// wmaster: Wishbone-style single-cycle bus initiator.
// A requester pushes commands into a small FIFO; each command is issued as
// one bus cycle (IDLE -> BUS -> RESP) and produces exactly one response pulse,
// in FIFO order. Bus address/data/we/tag are registered at pop and held for
// the whole BUS state; stb is low for at least two cycles between cycles.
// Optional feature macro: WMASTER_TIMEOUT_EN -- abort a bus cycle with
// rsp_err_o after TIMEOUT_CYCLES cycles without ack.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   req_valid_i/req_ready_o      command handshake (ready = FIFO not full)
//   req_we_i, req_adr_i, req_dat_i  command fields
//   rsp_valid_o                  one-cycle response pulse
//   rsp_dat_o, rsp_tag_o, rsp_err_o  read data, sampled slave tag, timeout flag
//   busy_o                       FSM not idle or FIFO not empty
//   cyc_o, stb_o, we_o, adr_o, dat_o, tagn_o  bus master outputs
//   ack_i, dat_i, tagn_i         bus slave inputs
module wmaster
  import wmaster_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [ADR_W-1:0] req_adr_i,
  input  logic [DAT_W-1:0] req_dat_i,
  output logic             rsp_valid_o,
  output logic [DAT_W-1:0] rsp_dat_o,
  output logic             rsp_tag_o,
  output logic             rsp_err_o,
  output logic             busy_o,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [ADR_W-1:0] adr_o,
  output logic [DAT_W-1:0] dat_o,
  output logic             tagn_o,
  input  logic             ack_i,
  input  logic [DAT_W-1:0] dat_i,
  input  logic             tagn_i
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("wmaster: TIMEOUT_CYCLES must be >= 1");
  end

  state_e           state_q, state_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [DAT_W-1:0] dat_q, dat_d;
  logic             we_q, we_d;
  logic [DAT_W-1:0] rsp_dat_q, rsp_dat_d;
  logic             rsp_tag_q, rsp_tag_d;

  logic fifo_pop, fifo_full, fifo_empty;
  cmd_t fifo_head, push_cmd;
  logic in_bus, in_resp;

`ifdef WMASTER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             rsp_err_q, rsp_err_d;
`endif

  assign push_cmd = {req_we_i, req_adr_i, req_dat_i};

  wmaster_cmd_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (req_valid_i),
    .push_data_i(push_cmd),
    .pop_i      (fifo_pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (fifo_head)
  );

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    we_d      = we_q;
    rsp_dat_d = rsp_dat_q;
    rsp_tag_d = rsp_tag_q;
    fifo_pop  = 1'b0;
`ifdef WMASTER_TIMEOUT_EN
    tmo_d     = tmo_q;
    rsp_err_d = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          adr_d    = fifo_head.adr;
          we_d     = fifo_head.we;
          dat_d    = fifo_head.we ? fifo_head.dat : '0;
          state_d  = BUS;
`ifdef WMASTER_TIMEOUT_EN
          tmo_d    = '0;
`endif
        end
      end
      BUS: begin
        // An ack in the same cycle the limit is reached takes priority.
        if (ack_i) begin
          rsp_dat_d = we_q ? '0 : dat_i;
          rsp_tag_d = tagn_i;
          state_d   = RESP;
`ifdef WMASTER_TIMEOUT_EN
          rsp_err_d = 1'b0;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_dat_d = '0;
          rsp_tag_d = 1'b0;
          rsp_err_d = 1'b1;
          state_d   = RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
`endif
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      rsp_dat_q <= '0;
      rsp_tag_q <= 1'b0;
`ifdef WMASTER_TIMEOUT_EN
      tmo_q     <= '0;
      rsp_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      we_q      <= we_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_tag_q <= rsp_tag_d;
`ifdef WMASTER_TIMEOUT_EN
      tmo_q     <= tmo_d;
      rsp_err_q <= rsp_err_d;
`endif
    end
  end

  // All bus/response outputs decode from registered state, so the
  // asynchronous reset clears them immediately.
  assign in_bus      = (state_q == BUS);
  assign in_resp     = (state_q == RESP);
  assign cyc_o       = in_bus;
  assign stb_o       = in_bus;
  assign we_o        = in_bus && we_q;
  assign tagn_o      = in_bus && is_ssp(adr_q);
  assign adr_o       = adr_q;
  assign dat_o       = dat_q;
  assign rsp_valid_o = in_resp;
  assign rsp_dat_o   = in_resp ? rsp_dat_q : '0;
  assign rsp_tag_o   = in_resp && rsp_tag_q;
`ifdef WMASTER_TIMEOUT_EN
  assign rsp_err_o   = in_resp && rsp_err_q;
`else
  assign rsp_err_o   = 1'b0;
`endif
  assign req_ready_o = !fifo_full;
  assign busy_o      = (state_q != IDLE) || !fifo_empty;

endmodule
